// File: rtl/matrix_commutator_n.sv
// Matrix-converter switch commutation controller: one independent four-step
// current-sign commutation FSM per output phase, with dead times and a latched short fault.
module matrix_commutator_n #(
    parameter int N_OUT = 3,
    parameter int M_IN  = 3,
    parameter int SELW  = 2,
    parameter int TDOFF = 10,
    parameter int TDON  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      short,
    input  logic [N_OUT-1:0]          CurrentSign,
    input  logic [N_OUT*SELW-1:0]     DesiredLoad,
    output logic [N_OUT*2*M_IN-1:0]   Sout,
    output logic [N_OUT-1:0]          busy,
    output logic [N_OUT-1:0]          bad_code,
    output logic                      fault
);

    localparam int TMAX = (TDOFF > TDON) ? TDOFF : TDON;
    localparam int TIMW = $clog2(TMAX + 1);
    localparam int FW   = 2 * M_IN;
    localparam logic [TIMW-1:0] TOFF_LD = TIMW'(TDOFF - 1);
    localparam logic [TIMW-1:0] TON_LD  = TIMW'(TDON - 1);
    localparam logic [SELW:0]   MAX_CODE = (SELW + 1)'(M_IN);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_ONWAIT = 3'd1,
        ST_CONN   = 3'd2,
        ST_STEP1  = 3'd3,
        ST_STEP2  = 3'd4,
        ST_STEP3  = 3'd5
    } state_t;

    // Places a two-bit device pattern on pair k of one output field.
    function automatic logic [FW-1:0] pair_f(input logic [SELW-1:0] k, input logic [1:0] v);
        logic [FW-1:0] f;
        f = '0;
        for (int j = 1; j <= M_IN; j++) begin
            if (k == SELW'(j)) begin
                f[2*(M_IN-j) +: 2] = v;
            end else begin
                f = f;
            end
        end
        return f;
    endfunction

    logic fault_q;
    logic trip_s;

    assign trip_s = fault_q | short;
    assign fault  = fault_q;

    // Short-circuit latch, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (short) begin
            fault_q <= 1'b1;
        end else begin
            fault_q <= fault_q;
        end
    end

    for (genvar n = 0; n < N_OUT; n++) begin : g_out
        logic [SELW-1:0] tgt_s;
        logic            tgt_bad_s;
        logic            sign_s;
        logic [1:0]      dev_now_s;
        logic [1:0]      dev_lat_s;
        state_t          state_q;
        logic [TIMW-1:0] tim_q;
        logic [SELW-1:0] cur_q;
        logic [SELW-1:0] nxt_q;
        logic            sgn_q;
        logic [FW-1:0]   field_q;
        logic            busy_q;
        logic            bad_q;

        // Target decode; the conducting device is forward for positive current.
        always_comb begin
            tgt_s     = '0;
            dev_now_s = 2'b01;
            dev_lat_s = 2'b01;
            if (start) begin
                tgt_s = DesiredLoad[(N_OUT-1-n)*SELW +: SELW];
            end else begin
                tgt_s = '0;
            end
            tgt_bad_s = ({1'b0, tgt_s} > MAX_CODE);
            sign_s    = CurrentSign[N_OUT-1-n];
            if (sign_s) begin
                dev_now_s = 2'b10;
            end else begin
                dev_now_s = 2'b01;
            end
            if (sgn_q) begin
                dev_lat_s = 2'b10;
            end else begin
                dev_lat_s = 2'b01;
            end
        end

        // Per-output commutation FSM with registered gate field and flags.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_OFF;
                tim_q   <= '0;
                cur_q   <= '0;
                nxt_q   <= '0;
                sgn_q   <= 1'b0;
                field_q <= '0;
                busy_q  <= 1'b0;
                bad_q   <= 1'b0;
            end else begin
                bad_q <= bad_q | tgt_bad_s;
                if (trip_s) begin
                    state_q <= ST_OFF;
                    tim_q   <= '0;
                    field_q <= '0;
                    busy_q  <= 1'b0;
                end else begin
                    case (state_q)
                        ST_OFF: begin
                            field_q <= '0;
                            if (!tgt_bad_s && (tgt_s != '0)) begin
                                state_q <= ST_ONWAIT;
                                nxt_q   <= tgt_s;
                                tim_q   <= TON_LD;
                            end
                        end
                        ST_ONWAIT: begin
                            if (!tgt_bad_s && (tgt_s == '0)) begin
                                state_q <= ST_OFF;
                                tim_q   <= '0;
                            end else if (!tgt_bad_s && (tgt_s != nxt_q)) begin
                                nxt_q <= tgt_s;
                                tim_q <= TON_LD;
                            end else if (tim_q == '0) begin
                                state_q <= ST_CONN;
                                cur_q   <= nxt_q;
                                field_q <= pair_f(nxt_q, 2'b11);
                            end else begin
                                tim_q <= tim_q - 1'b1;
                            end
                        end
                        ST_CONN: begin
                            if (tgt_bad_s || (tgt_s == cur_q)) begin
                                state_q <= ST_CONN;
                            end else if (tgt_s == '0) begin
                                state_q <= ST_OFF;
                                field_q <= '0;
                            end else begin
                                // Keep only the outgoing conducting device.
                                state_q <= ST_STEP1;
                                nxt_q   <= tgt_s;
                                sgn_q   <= sign_s;
                                busy_q  <= 1'b1;
                                tim_q   <= TOFF_LD;
                                field_q <= pair_f(cur_q, dev_now_s);
                            end
                        end
                        ST_STEP1: begin
                            if (tim_q == '0) begin
                                state_q <= ST_STEP2;
                                tim_q   <= TON_LD;
                                field_q <= pair_f(cur_q, dev_lat_s) | pair_f(nxt_q, dev_lat_s);
                            end else begin
                                tim_q <= tim_q - 1'b1;
                            end
                        end
                        ST_STEP2: begin
                            if (tim_q == '0) begin
                                state_q <= ST_STEP3;
                                tim_q   <= TOFF_LD;
                                field_q <= pair_f(nxt_q, dev_lat_s);
                            end else begin
                                tim_q <= tim_q - 1'b1;
                            end
                        end
                        ST_STEP3: begin
                            if (tim_q == '0) begin
                                state_q <= ST_CONN;
                                cur_q   <= nxt_q;
                                busy_q  <= 1'b0;
                                field_q <= pair_f(nxt_q, 2'b11);
                            end else begin
                                tim_q <= tim_q - 1'b1;
                            end
                        end
                        default: begin
                            state_q <= ST_OFF;
                            tim_q   <= '0;
                            field_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign Sout[(N_OUT-1-n)*FW +: FW] = field_q;
        assign busy[N_OUT-1-n]            = busy_q;
        assign bad_code[N_OUT-1-n]        = bad_q;
    end

endmodule

// File: tb/tb_matrix_commutator_n.sv
// Scoreboard bench for matrix_commutator_n: expectations are queued with a due
// cycle when stimulus is applied and compared on the falling edge when due.
module tb_matrix_commutator_n;

    localparam int K_SOUT  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_FAULT = 2;
    localparam int K_BAD   = 3;
    localparam int K_SOUT2 = 4;
    localparam int K_BAD2  = 5;

    logic        clk = 1'b0;
    logic        rst, start, shrt;
    logic [2:0]  sign;
    logic [5:0]  dl;
    logic [17:0] sout;
    logic [2:0]  busy, bad;
    logic        fault;

    logic        start2;
    logic [1:0]  sign2;
    logic [3:0]  dl2;
    logic [7:0]  sout2;
    logic [1:0]  busy2, bad2;
    logic        fault2;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int          due;
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matrix_commutator_n #(.N_OUT(3), .M_IN(3), .SELW(2), .TDOFF(10), .TDON(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .short(shrt), .CurrentSign(sign),
        .DesiredLoad(dl), .Sout(sout), .busy(busy), .bad_code(bad), .fault(fault)
    );

    matrix_commutator_n #(.N_OUT(2), .M_IN(2), .SELW(2), .TDOFF(10), .TDON(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .short(1'b0), .CurrentSign(sign2),
        .DesiredLoad(dl2), .Sout(sout2), .busy(busy2), .bad_code(bad2), .fault(fault2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int dly, input string tag, input int kind, input logic [31:0] exp);
        exp_t e;
        e.due  = cyc + dly;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    function automatic logic [5:0] pr(input int k, input logic [1:0] v);
        logic [5:0] f;
        f = '0;
        f[2*(3-k) +: 2] = v;
        return f;
    endfunction

    function automatic logic [31:0] f3(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        return {14'd0, a, b, c};
    endfunction

    function automatic logic [5:0] enc3(input int a, input int b, input int c);
        return {2'(a), 2'(b), 2'(c)};
    endfunction

    // A forward device of one input together with a reverse device of another shorts the inputs.
    function automatic logic cross6(input logic [5:0] f);
        logic r;
        r = 1'b0;
        for (int a = 1; a <= 3; a++)
            for (int b = 1; b <= 3; b++)
                if (a != b && f[2*(3-a)+1] && f[2*(3-b)]) r = 1'b1;
        return r;
    endfunction

    always @(negedge clk) begin : mon
        logic [31:0] obs;
        for (int j = sb_q.size() - 1; j >= 0; j--) begin
            if (sb_q[j].due == cyc) begin
                case (sb_q[j].kind)
                    K_SOUT:  obs = {14'd0, sout};
                    K_BUSY:  obs = {29'd0, busy};
                    K_FAULT: obs = {31'd0, fault};
                    K_BAD:   obs = {29'd0, bad};
                    K_SOUT2: obs = {24'd0, sout2};
                    default: obs = {30'd0, bad2};
                endcase
                check_eq(sb_q[j].tag, obs, sb_q[j].exp);
                sb_q.delete(j);
            end
        end
        if (rst === 1'b0) begin
            for (int n = 0; n < 3; n++)
                check_eq("no_cross", {31'd0, cross6(sout[6*(2-n) +: 6])}, 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; shrt = 1'b0; sign = 3'b000; dl = enc3(1, 2, 3);
        start2 = 1'b0; sign2 = 2'b00; dl2 = 4'b0000;

        // Reset state, then start low keeps everything off
        @(negedge clk);
        check_eq("rst_sout", {14'd0, sout}, 32'd0);
        check_eq("rst_busy", {29'd0, busy}, 32'd0);
        check_eq("rst_fault", {31'd0, fault}, 32'd0);
        check_eq("rst_bad", {29'd0, bad}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(4, "t1_sout_off", K_SOUT, 32'd0);
        push(4, "t1_busy", K_BUSY, 32'd0);
        repeat (5) @(negedge clk);

        // Turn-on from all-off: TDON+1 edges
        start = 1'b1;
        push(2, "t2_onwait", K_SOUT, 32'd0);
        push(3, "t2_on", K_SOUT, f3(pr(1, 2'b11), pr(2, 2'b11), pr(3, 2'b11)));
        repeat (5) @(negedge clk);

        // Four-step commutation, positive current
        sign = 3'b111; dl = enc3(2, 3, 1);
        push(0, "t3_pre_busy", K_BUSY, 32'd0);
        push(1, "t3_step1", K_SOUT, f3(pr(1, 2'b10), pr(2, 2'b10), pr(3, 2'b10)));
        push(1, "t3_busy_on", K_BUSY, 32'd7);
        push(10, "t3_step1_end", K_SOUT, f3(pr(1, 2'b10), pr(2, 2'b10), pr(3, 2'b10)));
        push(11, "t3_step2", K_SOUT, f3(pr(1, 2'b10) | pr(2, 2'b10), pr(2, 2'b10) | pr(3, 2'b10), pr(3, 2'b10) | pr(1, 2'b10)));
        push(13, "t3_step3", K_SOUT, f3(pr(2, 2'b10), pr(3, 2'b10), pr(1, 2'b10)));
        push(22, "t3_busy_last", K_BUSY, 32'd7);
        push(23, "t3_conn", K_SOUT, f3(pr(2, 2'b11), pr(3, 2'b11), pr(1, 2'b11)));
        push(23, "t3_busy_off", K_BUSY, 32'd0);
        repeat (5) @(negedge clk);

        // Mid-sequence change is ignored, then a negative-current sequence follows
        sign = 3'b000; dl = enc3(3, 1, 2);
        push(17, "t4_still_step3", K_SOUT, f3(pr(2, 2'b10), pr(3, 2'b10), pr(1, 2'b10)));
        push(19, "t4_step1", K_SOUT, f3(pr(2, 2'b01), pr(3, 2'b01), pr(1, 2'b01)));
        push(29, "t4_step2", K_SOUT, f3(pr(2, 2'b01) | pr(3, 2'b01), pr(3, 2'b01) | pr(1, 2'b01), pr(1, 2'b01) | pr(2, 2'b01)));
        push(41, "t4_conn", K_SOUT, f3(pr(3, 2'b11), pr(1, 2'b11), pr(2, 2'b11)));
        repeat (45) @(negedge clk);

        // Asynchronous reset during STEP2
        sign = 3'b111; dl = enc3(1, 2, 3);
        push(11, "t5_step2", K_SOUT, f3(pr(3, 2'b10) | pr(1, 2'b10), pr(1, 2'b10) | pr(2, 2'b10), pr(2, 2'b10) | pr(3, 2'b10)));
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_async_sout", {14'd0, sout}, 32'd0);
        check_eq("t5_async_busy", {29'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        dl = enc3(1, 1, 2);
        rst = 1'b0;
        push(2, "t5_onwait", K_SOUT, 32'd0);
        push(3, "t5_on", K_SOUT, f3(pr(1, 2'b11), pr(1, 2'b11), pr(2, 2'b11)));
        repeat (5) @(negedge clk);

        // Short fault latches and holds regardless of inputs
        shrt = 1'b1;
        @(negedge clk);
        shrt = 1'b0;
        push(1, "t6_fault", K_FAULT, 32'd1);
        push(1, "t6_sout_off", K_SOUT, 32'd0);
        push(20, "t6_fault_hold", K_FAULT, 32'd1);
        push(20, "t6_sout_hold", K_SOUT, 32'd0);
        repeat (5) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; dl = enc3(3, 2, 1);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dl = enc3(1, 1, 2);
        push(3, "t6_reconnect", K_SOUT, f3(pr(1, 2'b11), pr(1, 2'b11), pr(2, 2'b11)));
        push(3, "t6_fault_clr", K_FAULT, 32'd0);

        // Invalid code on a two-input instance: sticky flag, state held
        start2 = 1'b1; dl2 = {2'b01, 2'b11};
        push(1, "t7_bad_one", K_BAD2, 32'd1);
        push(3, "t7_sout2", K_SOUT2, 32'hC0);
        repeat (5) @(negedge clk);
        dl2 = {2'b11, 2'b11};
        push(2, "t7_bad_both", K_BAD2, 32'd3);
        push(3, "t7_hold_conn", K_SOUT2, 32'hC0);
        repeat (5) @(negedge clk);
        dl2 = {2'b01, 2'b00};
        push(3, "t7_bad_sticky", K_BAD2, 32'd3);
        push(3, "t7_sout2_b", K_SOUT2, 32'hC0);
        push(3, "t7_main_bad", K_BAD, 32'd0);
        repeat (6) @(negedge clk);

        check_eq("sb_drain", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
